// File: rtl/mem_stall_bridge.sv
// Bridge between a multicycle core's memory port and a valid/ready memory.
// Stalls the core during accesses, buffers one read, and flags timeouts.
module mem_stall_bridge #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wr_data,
    input  logic        core_wr_ena,
    output logic [31:0] core_rd_data,
    output logic        core_ena,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    output logic        req_wr,
    output logic [31:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        err,
    output logic [31:0] stall_count
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StWrCommit,
        StError
    } state_e;

    state_e          state_q, state_d;
    logic            buf_valid_q, buf_valid_d;
    logic [31:0]     buf_addr_q, buf_addr_d;
    logic [31:0]     buf_data_q, buf_data_d;
    logic            req_valid_q, req_valid_d;
    logic            req_wr_q, req_wr_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic [31:0]     req_wdata_q, req_wdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     stall_q, stall_d;
    logic            err_q, err_d;

    logic            hit;
    logic            ena;
    logic [CntW-1:0] cnt_next;
    logic            expire;

    always_comb begin
        hit      = buf_valid_q && (core_addr == buf_addr_q) && !core_wr_ena;
        ena      = ((state_q == StIdle) && hit) || (state_q == StWrCommit);
        cnt_next = cnt_q + CntW'(1);
        // Expiry is judged on the count this cycle would reach.
        expire   = (cnt_next == TimeoutVal);

        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        req_valid_d = req_valid_q;
        req_wr_d    = req_wr_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (!hit) begin
                    req_valid_d = 1'b1;
                    req_addr_d  = core_addr;
                    req_wr_d    = core_wr_ena;
                    req_wdata_d = core_wr_data;
                    cnt_d       = '0;
                    if (core_wr_ena) begin
                        buf_valid_d = 1'b0;
                    end
                    state_d = StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_next;
                if (req_ready && req_wr_q) begin
                    req_valid_d = 1'b0;
                    state_d     = StWrCommit;
                end else if (expire) begin
                    req_valid_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = StError;
                end else if (req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_next;
                if (rsp_valid) begin
                    buf_data_d  = rsp_data;
                    buf_addr_d  = req_addr_q;
                    buf_valid_d = 1'b1;
                    state_d     = StIdle;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = StError;
                end
            end
            StWrCommit: begin
                state_d = StIdle;
            end
            StError: begin
                req_valid_d = 1'b0;
                err_d       = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        stall_d = stall_q;
        if (!ena && (state_q != StError) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= 32'd0;
            buf_data_q  <= 32'd0;
            req_valid_q <= 1'b0;
            req_wr_q    <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            cnt_q       <= '0;
            stall_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            req_valid_q <= req_valid_d;
            req_wr_q    <= req_wr_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            cnt_q       <= cnt_d;
            stall_q     <= stall_d;
            err_q       <= err_d;
        end
    end

    assign core_rd_data = buf_data_q;
    assign core_ena     = ena;
    assign req_valid    = req_valid_q;
    assign req_addr     = req_addr_q;
    assign req_wr       = req_wr_q;
    assign req_wdata    = req_wdata_q;
    assign err          = err_q;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_mem_stall_bridge.sv
// Directed bench for mem_stall_bridge with TIMEOUT=8; memory handshakes are
// driven step by step from the stimulus sequence.
module tb_mem_stall_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] core_addr;
    logic [31:0] core_wr_data;
    logic        core_wr_ena;
    logic [31:0] core_rd_data;
    logic        core_ena;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        err;
    logic [31:0] stall_count;

    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    mem_stall_bridge #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .core_addr   (core_addr),
        .core_wr_data(core_wr_data),
        .core_wr_ena (core_wr_ena),
        .core_rd_data(core_rd_data),
        .core_ena    (core_ena),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wr      (req_wr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .err         (err),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && req_valid && req_ready) begin
            if (req_wr) wr_cnt <= wr_cnt + 1;
            else        rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        core_addr    = 32'h0;
        core_wr_data = 32'h0;
        core_wr_ena  = 1'b0;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_data     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();

        // Reset state; first fetch of 0x0 is a miss.
        chk("rst_core_ena", {31'd0, core_ena}, 32'd0);
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_stall", stall_count, 32'd0);
        chk("rst_rd_data", core_rd_data, 32'd0);
        chk("rst_req_addr", req_addr, 32'd0);

        // Read 0x0, response two cycles after acceptance.
        tick();
        req_ready = 1'b1;
        settle();
        chk("t1_req_valid", {31'd0, req_valid}, 32'd1);
        chk("t1_req_wr", {31'd0, req_wr}, 32'd0);
        tick();
        req_ready = 1'b0;
        settle();
        chk("t1_wait_reqv", {31'd0, req_valid}, 32'd0);
        tick();
        rsp_valid = 1'b1;
        rsp_data  = 32'h0050_0093;
        settle();
        chk("t1_rsp_ena", {31'd0, core_ena}, 32'd0);
        tick();
        rsp_valid = 1'b0;
        settle();
        chk("t1_ena", {31'd0, core_ena}, 32'd1);
        chk("t1_data", core_rd_data, 32'h0050_0093);
        chk("t1_stall", stall_count, 32'd4);

        // Fill 0x10, then hold it for 5 enabled cycles.
        core_addr = 32'h10;
        settle();
        chk("t2_miss", {31'd0, core_ena}, 32'd0);
        tick();
        req_ready = 1'b1;
        settle();
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'hA5A5_0010;
        tick();
        rsp_valid = 1'b0;
        settle();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_ena", {31'd0, core_ena}, 32'd1);
            chk("t2_hold_reqv", {31'd0, req_valid}, 32'd0);
            tick();
        end
        chk("t2_data", core_rd_data, 32'hA5A5_0010);
        chk("t2_rd_cnt", rd_cnt, 32'd2);
        chk("t2_stall", stall_count, 32'd7);

        // Store 0xDEADBEEF to 0x20 with 3 cycles of backpressure.
        core_addr    = 32'h20;
        core_wr_data = 32'hDEAD_BEEF;
        core_wr_ena  = 1'b1;
        settle();
        chk("t3_wr_ena", {31'd0, core_ena}, 32'd0);
        tick();
        core_wr_data = 32'h0;
        core_addr    = 32'h44;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) req_ready = 1'b1;
            settle();
            chk("t3_reqv", {31'd0, req_valid}, 32'd1);
            chk("t3_req_wr", {31'd0, req_wr}, 32'd1);
            chk("t3_req_addr", req_addr, 32'h20);
            chk("t3_req_wdata", req_wdata, 32'hDEAD_BEEF);
            chk("t3_stall_ena", {31'd0, core_ena}, 32'd0);
            tick();
        end
        req_ready   = 1'b0;
        core_wr_ena = 1'b0;
        core_addr   = 32'h10;
        settle();
        chk("t3_commit_ena", {31'd0, core_ena}, 32'd1);
        chk("t3_commit_reqv", {31'd0, req_valid}, 32'd0);
        chk("t3_commit_stall", stall_count, 32'd12);
        chk("t3_wr_cnt", wr_cnt, 32'd1);
        tick();
        chk("t3_refetch_miss", {31'd0, core_ena}, 32'd0);
        tick();
        req_ready = 1'b1;
        settle();
        chk("t3_refetch_addr", req_addr, 32'h10);
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h1111_1111;
        tick();
        rsp_valid = 1'b0;
        settle();
        chk("t3_refetch_ena", {31'd0, core_ena}, 32'd1);
        chk("t3_refetch_data", core_rd_data, 32'h1111_1111);
        chk("t3_rd_cnt", rd_cnt, 32'd3);
        chk("t3_stall", stall_count, 32'd15);

        // Response on the expiry cycle: 1 REQ + 7 WAIT cycles.
        core_addr = 32'h30;
        tick();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        repeat (6) tick();
        chk("t5_pre_err", {31'd0, err}, 32'd0);
        rsp_valid = 1'b1;
        rsp_data  = 32'h3030_3030;
        tick();
        rsp_valid = 1'b0;
        settle();
        chk("t5_err", {31'd0, err}, 32'd0);
        chk("t5_ena", {31'd0, core_ena}, 32'd1);
        chk("t5_data", core_rd_data, 32'h3030_3030);
        chk("t5_stall", stall_count, 32'd24);

        // req_ready stuck low: ERROR after 8 REQ cycles.
        core_addr = 32'h40;
        tick();
        repeat (7) tick();
        chk("t4_last_req_err", {31'd0, err}, 32'd0);
        chk("t4_last_req_v", {31'd0, req_valid}, 32'd1);
        tick();
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_ena", {31'd0, core_ena}, 32'd0);
        chk("t4_reqv", {31'd0, req_valid}, 32'd0);
        chk("t4_stall", stall_count, 32'd33);
        repeat (3) tick();
        chk("t4_err_sticky", {31'd0, err}, 32'd1);
        chk("t4_stall_frozen", stall_count, 32'd33);

        // Reset clears ERROR; then reset during WAIT and a late response.
        rst = 1'b1;
        settle();
        chk("t6_err_clr", {31'd0, err}, 32'd0);
        tick();
        rst       = 1'b0;
        core_addr = 32'h50;
        tick();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        settle();
        chk("t6_in_wait", stall_count, 32'd2);
        rst       = 1'b1;
        core_addr = 32'h0;
        settle();
        chk("t6_rst_ena", {31'd0, core_ena}, 32'd0);
        chk("t6_rst_reqv", {31'd0, req_valid}, 32'd0);
        chk("t6_rst_stall", stall_count, 32'd0);
        chk("t6_rst_rdata", core_rd_data, 32'd0);
        chk("t6_rst_addr", req_addr, 32'd0);
        tick();
        rst       = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h0000_0BAD;
        settle();
        chk("t6_late_ena", {31'd0, core_ena}, 32'd0);
        tick();
        rsp_valid = 1'b0;
        settle();
        chk("t6_late_rdata", core_rd_data, 32'd0);
        chk("t6_late_ena2", {31'd0, core_ena}, 32'd0);
        chk("t6_refetch_reqv", {31'd0, req_valid}, 32'd1);
        chk("t6_err", {31'd0, err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
